// File: rtl/smvm_pkg.sv
// Shared types for the CSR sparse matrix-vector datapath.
//   disp_state_t : dispatcher FSM encoding
//   csr_beat_t   : one output beat (row, val, col, first, last, empty) at the
//                  default widths shared with the row multiplier
package smvm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    CHK  = 3'd3,
    NZ   = 3'd4,
    EMIT = 3'd5,
    DONE = 3'd6
  } disp_state_t;

  localparam int SMVM_N      = 100;
  localparam int SMVM_NNZ    = 100;
  localparam int SMVM_DATA_W = 32;
  localparam int SMVM_ROW_W  = $clog2(SMVM_N + 1);
  localparam int SMVM_PTR_W  = $clog2(SMVM_NNZ + 1);

  typedef struct packed {
    logic [SMVM_ROW_W-1:0]  row;
    logic [SMVM_DATA_W-1:0] val;
    logic [SMVM_ROW_W-1:0]  col;
    logic                   first;
    logic                   last;
    logic                   empty;
  } csr_beat_t;

  localparam int CSR_BEAT_W = $bits(csr_beat_t);

endpackage

// File: rtl/csr_row_dispatcher.sv
// CSR row dispatcher: walks row_ptr, fetches each row's nonzeros from the
// val/col memory and streams one beat per nonzero (or one marker beat per
// empty/malformed row) to the downstream row MAC.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, n_rows            pass request (IDLE only), row count (clamped to N)
//   busy, done, err          pass status; err is sticky until next start
//   rp_addr / rp_rdata       row_ptr memory port, 1-cycle read latency
//   nz_addr / nz_val, nz_col val/col memory port, 1-cycle read latency
//   out_valid / out_ready    beat handshake
//   out_row, out_val, out_col, out_first, out_last, out_empty  beat payload
//
// state | meaning
// IDLE  | waiting for start
// P0    | read row_ptr[0]
// P1    | capture row start pointer, read row_ptr[row+1]
// CHK   | capture row end pointer, classify row, issue first nonzero read
// NZ    | load beat from val/col memory
// EMIT  | hold beat until accepted, then issue next read
// DONE  | one-cycle done pulse
module csr_row_dispatcher
  import smvm_pkg::*;
#(
  parameter int N      = 100,
  parameter int NNZ    = 100,
  parameter int DATA_W = 32,
  parameter int ROW_W  = $clog2(N + 1),
  parameter int PTR_W  = $clog2(NNZ + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  n_rows,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ROW_W-1:0]  rp_addr,
  input  logic [PTR_W-1:0]  rp_rdata,
  output logic [PTR_W-1:0]  nz_addr,
  input  logic [DATA_W-1:0] nz_val,
  input  logic [ROW_W-1:0]  nz_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic [DATA_W-1:0] out_val,
  output logic [ROW_W-1:0]  out_col,
  output logic              out_first,
  output logic              out_last,
  output logic              out_empty
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N);
  localparam logic [PTR_W:0]   PTR_MAX = (PTR_W + 1)'(NNZ);

  disp_state_t state;

  logic [ROW_W-1:0] nRowsQ;
  logic [ROW_W-1:0] row;
  logic [PTR_W-1:0] curPtr;
  logic [PTR_W-1:0] endPtr;
  logic [PTR_W-1:0] idx;
  logic             rowBad;

  logic [ROW_W-1:0] nRowsClamped;
  logic [ROW_W:0]   rowNext;
  logic             moreRows;
  logic [PTR_W:0]   idxNext;
  logic             nzLast;
  logic             rowEmpty;
  logic             rowMalformed;
  logic             handshake;

  assign nRowsClamped = (n_rows > ROW_MAX) ? ROW_MAX : n_rows;
  assign rowNext      = {1'b0, row} + 1'b1;
  assign moreRows     = rowNext < {1'b0, nRowsQ};
  assign idxNext      = {1'b0, idx} + 1'b1;
  assign nzLast       = idxNext == {1'b0, endPtr};
  assign rowEmpty     = rp_rdata == curPtr;
  // An end pointer behind the start or past the nonzero array is unusable;
  // the row still gets a marker beat so the downstream row count stays intact.
  assign rowMalformed = (rp_rdata < curPtr) || ({1'b0, rp_rdata} > PTR_MAX);
  assign handshake    = (state == EMIT) && out_ready;

  assign out_valid = state == EMIT;
  assign done      = state == DONE;
  assign busy      = (state != IDLE) && (state != DONE);

  // Reads are issued only on the transitions that need them, so every
  // row_ptr entry is fetched exactly once per pass.
  always_comb begin
    rp_addr = '0;
    nz_addr = '0;
    case (state)
      P1:      rp_addr = rowNext[ROW_W-1:0];
      CHK:     if (!rowEmpty && !rowMalformed) nz_addr = curPtr;
      EMIT: begin
        if (handshake) begin
          if (!out_last) nz_addr = idxNext[PTR_W-1:0];
          else if (moreRows) rp_addr = row + ROW_W'(2);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      nRowsQ    <= '0;
      row       <= '0;
      curPtr    <= '0;
      endPtr    <= '0;
      idx       <= '0;
      rowBad    <= 1'b0;
      err       <= 1'b0;
      out_row   <= '0;
      out_val   <= '0;
      out_col   <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_empty <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err    <= 1'b0;
            nRowsQ <= nRowsClamped;
            row    <= '0;
            state  <= (nRowsClamped == '0) ? DONE : P0;
          end
        end
        P0: state <= P1;
        P1: begin
          curPtr <= rp_rdata;
          state  <= CHK;
        end
        CHK: begin
          endPtr <= rp_rdata;
          rowBad <= rowMalformed;
          if (rowEmpty || rowMalformed) begin
            if (rowMalformed) err <= 1'b1;
            out_row   <= row;
            out_val   <= '0;
            out_col   <= '0;
            out_first <= 1'b1;
            out_last  <= 1'b1;
            out_empty <= 1'b1;
            state     <= EMIT;
          end else begin
            idx   <= curPtr;
            state <= NZ;
          end
        end
        NZ: begin
          out_row   <= row;
          out_val   <= nz_val;
          out_col   <= nz_col;
          out_first <= idx == curPtr;
          out_last  <= nzLast;
          out_empty <= 1'b0;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (!out_last) begin
              idx   <= idxNext[PTR_W-1:0];
              state <= NZ;
            end else if (moreRows) begin
              row <= rowNext[ROW_W-1:0];
              // A bad row's end pointer is not trusted as the next start.
              if (!rowBad) curPtr <= endPtr;
              state <= CHK;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
